// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture sequencer: arms on SCCB completion, frames pixels between VSYNC edges,
// validates pixel counts and ping-pongs two frame-buffer banks against the VGA reader.
module ov7670_capture_ctrl #(
  parameter int H_WIDTH        = 320,
  parameter int V_WIDTH        = 240,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_WIDTH      = 16,
  localparam int FRAME_PIX     = H_WIDTH * V_WIDTH,
  localparam int AW            = $clog2(FRAME_PIX)
) (
  input  logic                 i_clk,
  input  logic                 i_n_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_continuous,
  input  logic                 i_cfg_done,
  input  logic                 i_vs,
  input  logic                 i_valid,
  input  logic                 i_rd_frame_start,
  output logic [5:0]           o_state,
  output logic                 o_en_xclk,
  output logic                 o_wr_en,
  output logic [AW-1:0]        o_wr_addr,
  output logic                 o_wr_bank,
  output logic                 o_rd_bank,
  output logic                 o_frame_done,
  output logic                 o_frame_err,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_frame_count,
  output logic [CNT_WIDTH-1:0] o_drop_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int PW = $clog2(FRAME_PIX + 2);
  localparam logic [PW-1:0] PIX_FULL = PW'(FRAME_PIX);
  localparam logic [PW-1:0] PIX_SAT  = PW'(FRAME_PIX + 1);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [5:0] {
    IDLE       = 6'b000001,
    WAIT_CFG   = 6'b000010,
    WAIT_VSYNC = 6'b000100,
    CAPTURE    = 6'b001000,
    CHECK      = 6'b010000,
    HOLD       = 6'b100000
  } state_t;

  state_t        state, state_next;
  logic          vs_d;
  logic          vs_fall, vs_rise;
  logic [PW-1:0] pix_cnt;
  logic          ready;
  logic          swap;
  logic          done_set, err_set;
  logic          wd_hit, wd_enter, wd_active;

  assign vs_fall   = vs_d & ~i_vs;
  assign vs_rise   = ~vs_d & i_vs;
  assign swap      = i_rd_frame_start & ready;
  assign wd_active = (state == WAIT_VSYNC) || (state == CAPTURE);
  assign wd_enter  = (state_next != state) &&
                     ((state_next == WAIT_VSYNC) || (state_next == CAPTURE));

  assign o_state   = state;
  assign o_en_xclk = 1'b1;
  assign o_wr_en   = i_valid && (state == CAPTURE) && (pix_cnt < PIX_FULL);
  assign o_wr_addr = pix_cnt[AW-1:0];

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE:       if (i_start) state_next = WAIT_CFG;
      WAIT_CFG:   if (i_cfg_done) state_next = WAIT_VSYNC;
      WAIT_VSYNC: if (vs_fall) state_next = CAPTURE;
      CAPTURE: begin
        // A stalled frame is discarded; the next VSYNC gets a fresh attempt.
        if (wd_hit)       state_next = WAIT_VSYNC;
        else if (vs_rise) state_next = CHECK;
      end
      CHECK: begin
        if (pix_cnt == PIX_FULL) begin
          done_set   = 1'b1;
          state_next = i_continuous ? HOLD : IDLE;
        end else begin
          err_set    = 1'b1;
          state_next = WAIT_VSYNC;
        end
      end
      HOLD:       if (!ready) state_next = WAIT_VSYNC;
      default:    state_next = IDLE;
    endcase
    if (i_stop) begin
      state_next = IDLE;
      done_set   = 1'b0;
      err_set    = 1'b0;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [WW-1:0] wd_cnt;
      assign wd_hit = wd_active && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
      always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset)              wd_cnt <= '0;
        else if (wd_enter || wd_hit) wd_cnt <= '0;
        else if (wd_active)          wd_cnt <= wd_cnt + WW'(1);
      end
    end else begin : g_no_wd
      assign wd_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state         <= IDLE;
      vs_d          <= 1'b0;
      pix_cnt       <= '0;
      ready         <= 1'b0;
      o_wr_bank     <= 1'b1;
      o_rd_bank     <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_timeout     <= 1'b0;
      o_frame_count <= '0;
      o_drop_count  <= '0;
      o_err_count   <= '0;
    end else begin
      state        <= state_next;
      vs_d         <= i_vs;
      o_frame_done <= done_set;
      o_frame_err  <= err_set;
      o_timeout    <= wd_hit;
      // Saturating one past full lets overrun frames fail the count check.
      if (state == WAIT_VSYNC && vs_fall)
        pix_cnt <= '0;
      else if (state == CAPTURE && i_valid && pix_cnt != PIX_SAT)
        pix_cnt <= pix_cnt + PW'(1);
      if (done_set) o_frame_count <= o_frame_count + CNT_WIDTH'(1);
      if (err_set)  o_err_count   <= o_err_count + CNT_WIDTH'(1);
      if (state == HOLD && vs_fall) o_drop_count <= o_drop_count + CNT_WIDTH'(1);
      if (swap) begin
        o_rd_bank <= o_wr_bank;
        o_wr_bank <= ~o_wr_bank;
      end
      // A frame completing alongside a reader frame start waits for the next one.
      if (done_set)  ready <= 1'b1;
      else if (swap) ready <= 1'b0;
    end
  end

endmodule
